// File: rtl/layer_pkg.sv
// Shared types and constants for the programmable VGA layer scheduler.
package layer_pkg;

  localparam int unsigned NUM_LAYERS = 8;
  localparam int unsigned LAYER_W    = 3;
  localparam int unsigned RGB_W      = 8;
  localparam int unsigned CNT_W      = 8;

  typedef logic [RGB_W-1:0]   rgb_t;
  typedef logic [LAYER_W-1:0] layer_idx_t;

  typedef enum logic [1:0] {IDLE, PENDING, APPLY} cfg_state_t;

  typedef struct packed {
    logic [LAYER_W-1:0] prio;
    logic               enable;
    logic               blink;
  } layer_cfg_t;

  typedef struct packed {
    layer_idx_t layer;
    layer_cfg_t cfg;
  } cfg_write_t;

  // One comparator-tree node: candidate request with its priority and origin.
  typedef struct packed {
    logic               valid;
    logic [LAYER_W-1:0] prio;
    layer_idx_t         idx;
  } cand_t;

  function automatic layer_cfg_t reset_cfg(input int unsigned idx);
    layer_cfg_t c;
    c.prio   = LAYER_W'(idx);
    c.enable = 1'b1;
    c.blink  = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/layer_prio_select.sv
// Combinational min-priority finder; balanced tree keeps depth at log2(NUM_LAYERS).
module layer_prio_select
  import layer_pkg::*;
(
  input  logic [NUM_LAYERS-1:0]              eff,
  input  logic [NUM_LAYERS-1:0][LAYER_W-1:0] prio,
  output layer_idx_t                         win_idx_c,
  output logic                               win_valid_c
);

  cand_t node [NUM_LAYERS];

  // Left (lower-index) node keeps the slot unless the right one is strictly better.
  always_comb begin
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      node[i].valid = eff[i];
      node[i].prio  = prio[i];
      node[i].idx   = LAYER_W'(i);
    end
    for (int unsigned lvl = 0; lvl < LAYER_W; lvl++) begin
      for (int unsigned i = 0; i + (1 << lvl) < NUM_LAYERS; i += (2 << lvl)) begin
        if (node[i + (1 << lvl)].valid &&
            (!node[i].valid || (node[i + (1 << lvl)].prio < node[i].prio))) begin
          node[i] = node[i + (1 << lvl)];
        end
      end
    end
    win_idx_c   = node[0].idx;
    win_valid_c = node[0].valid;
  end

endmodule

// File: rtl/layer_scheduler.sv
// Run-time programmable layer arbiter: frame-synchronous config, blink, overlap flags.
module layer_scheduler
  import layer_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic [NUM_LAYERS-1:0] layerDR,
  input  rgb_t                  layerRGB [NUM_LAYERS],
  input  rgb_t                  backgroundRGB,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  layer_idx_t            cfg_layer,
  input  logic [LAYER_W-1:0]    cfg_prio,
  input  logic                  cfg_enable,
  input  logic                  cfg_blink,
  output rgb_t                  RGBOut,
  output layer_idx_t            winLayer,
  output logic                  winValid,
  output logic [NUM_LAYERS-1:0] collisionMask
);

  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

  cfg_state_t            state_q, state_d;
  cfg_write_t            shadow_q, shadow_d;
  layer_cfg_t            cfg_q [NUM_LAYERS];
  layer_cfg_t            cfg_d [NUM_LAYERS];
  logic                  blink_phase_q, blink_phase_d;
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
  rgb_t                  rgb_q, rgb_d;
  layer_idx_t            win_layer_q, win_layer_d;
  logic                  win_valid_q, win_valid_d;
  logic [NUM_LAYERS-1:0] mask_q, mask_d;
  logic [NUM_LAYERS-1:0] acc_q, acc_d;
  logic                  cfg_ready_q, cfg_ready_d;

  logic [NUM_LAYERS-1:0]              eff_c;
  logic [NUM_LAYERS-1:0]              overlap_c;
  logic [NUM_LAYERS-1:0][LAYER_W-1:0] prio_c;
  layer_idx_t                         sel_idx_c;
  logic                               sel_valid_c;

  // Effective requests; overlap term is eff itself when two or more bits are set.
  always_comb begin
    eff_c  = '0;
    prio_c = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      eff_c[i]  = layerDR[i] & cfg_q[i].enable & ~(cfg_q[i].blink & blink_phase_q);
      prio_c[i] = cfg_q[i].prio;
    end
    overlap_c = ((eff_c & (eff_c - NUM_LAYERS'(1))) != '0) ? eff_c : '0;
  end

  layer_prio_select u_prio_select (
    .eff         (eff_c),
    .prio        (prio_c),
    .win_idx_c   (sel_idx_c),
    .win_valid_c (sel_valid_c)
  );

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    cfg_d         = cfg_q;
    blink_phase_d = blink_phase_q;
    frame_cnt_d   = frame_cnt_q;
    mask_d        = mask_q;
    acc_d         = acc_q | overlap_c;
    rgb_d         = sel_valid_c ? layerRGB[sel_idx_c] : backgroundRGB;
    win_layer_d   = sel_valid_c ? sel_idx_c : '0;
    win_valid_d   = sel_valid_c;

    // The startOfFrame pixel already belongs to the new frame's accumulation.
    if (startOfFrame) begin
      mask_d = acc_q;
      acc_d  = overlap_c;
      if (frame_cnt_q == BLINK_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          shadow_d.layer       = cfg_layer;
          shadow_d.cfg.prio    = cfg_prio;
          shadow_d.cfg.enable  = cfg_enable;
          shadow_d.cfg.blink   = cfg_blink;
          state_d              = PENDING;
        end
      end
      PENDING: begin
        if (startOfFrame) state_d = APPLY;
      end
      APPLY: begin
        cfg_d[shadow_q.layer] = shadow_q.cfg;
        state_d               = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cfg_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      for (int unsigned i = 0; i < NUM_LAYERS; i++) cfg_q[i] <= reset_cfg(i);
      blink_phase_q <= 1'b0;
      frame_cnt_q   <= '0;
      rgb_q         <= '0;
      win_layer_q   <= '0;
      win_valid_q   <= 1'b0;
      mask_q        <= '0;
      acc_q         <= '0;
      cfg_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      cfg_q         <= cfg_d;
      blink_phase_q <= blink_phase_d;
      frame_cnt_q   <= frame_cnt_d;
      rgb_q         <= rgb_d;
      win_layer_q   <= win_layer_d;
      win_valid_q   <= win_valid_d;
      mask_q        <= mask_d;
      acc_q         <= acc_d;
      cfg_ready_q   <= cfg_ready_d;
    end
  end

  assign cfg_ready     = cfg_ready_q;
  assign RGBOut        = rgb_q;
  assign winLayer      = win_layer_q;
  assign winValid      = win_valid_q;
  assign collisionMask = mask_q;

endmodule

// File: tb/tb_layer_scheduler.sv
// Directed bench for layer_scheduler: arbitration, frame-synced config, blink, overlap flags.
module tb_layer_scheduler;
  import layer_pkg::*;

  logic                  clk = 1'b0;
  logic                  resetN;
  logic                  sof;
  logic [NUM_LAYERS-1:0] dr;
  rgb_t                  layer_rgb [NUM_LAYERS];
  rgb_t                  bg;
  logic                  cfg_valid;
  logic                  cfg_ready;
  layer_idx_t            cfg_layer;
  logic [LAYER_W-1:0]    cfg_prio;
  logic                  cfg_enable;
  logic                  cfg_blink;
  rgb_t                  RGBOut;
  layer_idx_t            winLayer;
  logic                  winValid;
  logic [NUM_LAYERS-1:0] collisionMask;

  int checks   = 0;
  int failures = 0;

  layer_scheduler #(.BLINK_FRAMES(2)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (sof),
    .layerDR       (dr),
    .layerRGB      (layer_rgb),
    .backgroundRGB (bg),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_layer     (cfg_layer),
    .cfg_prio      (cfg_prio),
    .cfg_enable    (cfg_enable),
    .cfg_blink     (cfg_blink),
    .RGBOut        (RGBOut),
    .winLayer      (winLayer),
    .winValid      (winValid),
    .collisionMask (collisionMask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pix(input string tag, input rgb_t exp_rgb, input layer_idx_t exp_layer,
                           input logic exp_valid);
    checks++;
    assert (RGBOut === exp_rgb) else begin
      failures++;
      $error("FAIL %s RGBOut observed=0x%02h expected=0x%02h", tag, RGBOut, exp_rgb);
    end
    checks++;
    assert (winLayer === exp_layer) else begin
      failures++;
      $error("FAIL %s winLayer observed=%0d expected=%0d", tag, winLayer, exp_layer);
    end
    checks++;
    assert (winValid === exp_valid) else begin
      failures++;
      $error("FAIL %s winValid observed=%b expected=%b", tag, winValid, exp_valid);
    end
  endtask

  task automatic check_mask(input string tag, input logic [NUM_LAYERS-1:0] exp_mask);
    checks++;
    assert (collisionMask === exp_mask) else begin
      failures++;
      $error("FAIL %s collisionMask observed=0x%02h expected=0x%02h", tag, collisionMask, exp_mask);
    end
  endtask

  task automatic check_ready(input string tag, input logic exp_ready);
    checks++;
    assert (cfg_ready === exp_ready) else begin
      failures++;
      $error("FAIL %s cfg_ready observed=%b expected=%b", tag, cfg_ready, exp_ready);
    end
  endtask

  initial begin
    resetN = 1'b0; sof = 1'b0; dr = '0; bg = 8'h5C;
    cfg_valid = 1'b0; cfg_layer = '0; cfg_prio = '0; cfg_enable = 1'b0; cfg_blink = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) layer_rgb[i] = 8'(32'hA0 + i);
    tick(); tick();
    check_pix("reset", 8'h00, 3'd0, 1'b0);
    check_mask("reset_mask", 8'h00);
    check_ready("reset_ready", 1'b1);
    resetN = 1'b1;
    tick();

    // Default priorities
    dr = 8'h06; tick(); check_pix("default_prio", 8'hA1, 3'd1, 1'b1);
    dr = 8'h00; tick(); check_pix("background", 8'h5C, 3'd0, 1'b0);
    check_mask("mask_before_sof", 8'h00);
    sof = 1'b1; tick(); sof = 1'b0;
    check_mask("mask_default_overlap", 8'h06);

    // Reprioritise layer 2 to 0 mid-frame
    dr = 8'h06; cfg_valid = 1'b1; cfg_layer = 3'd2; cfg_prio = 3'd0; cfg_enable = 1'b1; cfg_blink = 1'b0;
    tick(); cfg_valid = 1'b0;
    check_ready("ready_drop", 1'b0);
    check_pix("pend_old", 8'hA1, 3'd1, 1'b1);
    tick(); tick();
    check_pix("pend_old2", 8'hA1, 3'd1, 1'b1);
    check_ready("ready_pend", 1'b0);
    sof = 1'b1; tick(); sof = 1'b0;
    check_pix("sof_pix_old", 8'hA1, 3'd1, 1'b1);
    check_mask("mask_frame2", 8'h06);
    tick();
    check_pix("apply_pix_old", 8'hA1, 3'd1, 1'b1);
    check_ready("ready_back", 1'b1);
    tick();
    check_pix("reprio_new", 8'hA2, 3'd2, 1'b1);

    // Write coincident with startOfFrame waits a full frame
    dr = 8'h22; sof = 1'b1; cfg_valid = 1'b1; cfg_layer = 3'd5; cfg_prio = 3'd0;
    tick(); sof = 1'b0; cfg_valid = 1'b0;
    check_pix("coinc_old", 8'hA1, 3'd1, 1'b1);
    check_ready("coinc_ready", 1'b0);
    tick(); tick(); tick();
    check_pix("coinc_wait", 8'hA1, 3'd1, 1'b1);
    check_ready("coinc_pend", 1'b0);
    sof = 1'b1; tick(); sof = 1'b0;
    check_pix("coinc_sof_old", 8'hA1, 3'd1, 1'b1);
    tick();
    check_pix("coinc_apply_old", 8'hA1, 3'd1, 1'b1);
    tick();
    check_pix("coinc_new", 8'hA5, 3'd5, 1'b1);

    // Equal priorities resolve to the lower index
    dr = 8'h21; tick(); check_pix("tie_0_vs_5", 8'hA0, 3'd0, 1'b1);
    dr = 8'h24; tick(); check_pix("tie_2_vs_5", 8'hA2, 3'd2, 1'b1);

    // Overlap flags
    dr = 8'h00; sof = 1'b1; tick(); sof = 1'b0;
    check_mask("mask_or_accum", 8'h27);
    dr = 8'h11; tick(); check_pix("collide_win", 8'hA0, 3'd0, 1'b1);
    dr = 8'h01; tick();
    dr = 8'h00; tick();
    sof = 1'b1; tick(); sof = 1'b0;
    check_mask("mask_frame_n", 8'h11);
    dr = 8'h10; tick();
    dr = 8'h02; tick();
    dr = 8'h00; tick();
    check_mask("mask_held", 8'h11);
    sof = 1'b1; tick(); sof = 1'b0;
    check_mask("mask_clear", 8'h00);
    dr = 8'h11; sof = 1'b1; tick(); sof = 1'b0; dr = 8'h00;
    check_mask("mask_quiet_frame", 8'h00);
    tick();
    sof = 1'b1; tick(); sof = 1'b0;
    check_mask("mask_sof_pixel", 8'h11);

    // Reset while a write is pending
    cfg_valid = 1'b1; cfg_layer = 3'd0; cfg_prio = 3'd7; cfg_enable = 1'b1; cfg_blink = 1'b0;
    tick(); cfg_valid = 1'b0;
    check_ready("pend_before_reset", 1'b0);
    resetN = 1'b0; #2;
    check_ready("async_reset_ready", 1'b1);
    check_pix("async_reset_pix", 8'h00, 3'd0, 1'b0);
    check_mask("async_reset_mask", 8'h00);
    tick(); resetN = 1'b1;
    dr = 8'h06; tick(); check_pix("reset_prio2", 8'hA1, 3'd1, 1'b1);
    dr = 8'h22; tick(); check_pix("reset_prio5", 8'hA1, 3'd1, 1'b1);
    dr = 8'h00; sof = 1'b1; tick(); sof = 1'b0;
    tick(); tick();
    dr = 8'h03; tick(); check_pix("shadow_discarded", 8'hA0, 3'd0, 1'b1);

    // Blink, two frames per half-period; one frame already counted since reset
    cfg_valid = 1'b1; cfg_layer = 3'd3; cfg_prio = 3'd3; cfg_enable = 1'b1; cfg_blink = 1'b1;
    dr = 8'h08; tick(); cfg_valid = 1'b0; cfg_blink = 1'b0;
    check_pix("blink_not_yet", 8'hA3, 3'd3, 1'b1);
    sof = 1'b1; tick(); sof = 1'b0;
    check_pix("blink_sof_old", 8'hA3, 3'd3, 1'b1);
    tick(); check_pix("blink_apply_old", 8'hA3, 3'd3, 1'b1);
    tick(); check_pix("blink_hidden1", 8'h5C, 3'd0, 1'b0);
    sof = 1'b1; tick(); sof = 1'b0;
    tick(); check_pix("blink_hidden2", 8'h5C, 3'd0, 1'b0);
    sof = 1'b1; tick(); sof = 1'b0;
    check_pix("blink_edge_old", 8'h5C, 3'd0, 1'b0);
    tick(); check_pix("blink_visible1", 8'hA3, 3'd3, 1'b1);
    sof = 1'b1; tick(); sof = 1'b0;
    tick(); check_pix("blink_visible2", 8'hA3, 3'd3, 1'b1);
    sof = 1'b1; tick(); sof = 1'b0;
    check_pix("blink_edge_vis", 8'hA3, 3'd3, 1'b1);
    tick(); check_pix("blink_hidden3", 8'h5C, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
